video_timing_gen: RTL and testbench

- Generates HDMI/DVI raster timing and pixel stream for the HDMI output path.
- Pulls 24-bit pixels from an upstream pixel FIFO (first-word-fall-through off, 1-cycle read latency).
- Drives rgb/hsync/vsync/de straight into the TMDS encode/serialize controller in the pixel clock domain.
- Defaults are 1280x720@60 at a 74.25 MHz pixel clock.

---
 rtl/video_timing_gen_if.sv | 35 +++
 rtl/video_timing_gen.sv | 155 +++++++++++++++
 tb/tb_video_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Pixel-path bundle for the raster timing generator: FIFO pull side and video output side.
// Latency: none (wires only).
// Backpressure: none; the FIFO side is a read strobe plus empty flag, the video side is free-running.
//
// Signals:
//   pix_data    FIFO read data {R,G,B}, valid the cycle after pix_rd
//   pix_empty   FIFO empty
//   pix_rd      FIFO read strobe
//   rgb_out     pixel to encoder
//   hsync_out   horizontal sync (polarity-adjusted)
//   vsync_out   vertical sync (polarity-adjusted)
//   de_out      data enable
//   frame_start one-cycle pulse on the first active pixel of a frame
interface video_timing_gen_if;
  logic [23:0] pix_data;
  logic        pix_empty;
  logic        pix_rd;
  logic [23:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic        frame_start;

  // master: the timing generator
  modport master (
    input  pix_data, pix_empty,
    output pix_rd, rgb_out, hsync_out, vsync_out, de_out, frame_start
  );

  // slave: FIFO + encoder side
  modport slave (
    output pix_data, pix_empty,
    input  pix_rd, rgb_out, hsync_out, vsync_out, de_out, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pulls pixels from a 1-cycle-latency FIFO and emits rgb/hsync/vsync/de.
// Latency: outputs trail the h/v counters by 2 cycles; pix_rd is combinational off the counters.
// Backpressure: none downstream; an empty FIFO during active video emits UNDERFLOW_RGB and sets a sticky flag.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   en              run request, sampled only at frame boundaries (IDLE, or last pixel of a frame)
//   clr_underflow   clears the sticky underflow flag (a same-cycle set wins)
//   underflow       sticky: an active pixel was due while the FIFO was empty
//   running         high while in RUN
//   vid             FIFO read side and video output side (video_timing_gen_if.master)
module video_timing_gen #(
  parameter int          H_ACTIVE      = 1280,
  parameter int          H_FP          = 110,
  parameter int          H_SYNC        = 40,
  parameter int          H_BP          = 220,
  parameter int          V_ACTIVE      = 720,
  parameter int          V_FP          = 5,
  parameter int          V_SYNC        = 5,
  parameter int          V_BP          = 20,
  parameter logic        HS_POL        = 1'b1,
  parameter logic        VS_POL        = 1'b1,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr_underflow,
  output logic            underflow,
  output logic            running,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // stage 1
  logic act1_q, hs1_q, vs1_q, got1_q, first1_q;
  // stage 2 / outputs
  logic        de_q, hsync_q, vsync_q, fs_q;
  logic [23:0] rgb_q, rgb_d;
  logic        underflow_q, underflow_d;

  // stage 0 decode
  logic run0, act0, hs0, vs0, first0, rd0;
  logic h_last, v_last;
  int   h_i, v_i;

  // Compare in int so sync windows that touch the total never wrap in the narrow counter width.
  assign h_i    = int'(h_q);
  assign v_i    = int'(v_q);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // Everything in stage 0 is gated by RUN so IDLE (counters parked at 0,0) reads as blanking.
  assign run0   = (state_q == ST_RUN);
  assign act0   = run0 && (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign hs0    = run0 && (h_i >= HS_START) && (h_i < HS_END);
  assign vs0    = run0 && (v_i >= VS_START) && (v_i < VS_END);
  assign first0 = (h_q == '0) && (v_q == '0);
  assign rd0    = act0 && !vid.pix_empty;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (state_q == ST_IDLE) begin
      h_d = '0;
      v_d = '0;
      if (en) state_d = ST_RUN;
    end else begin
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d = '0;
          // Frame boundary is the only point where a stop request takes effect.
          if (!en) state_d = ST_IDLE;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  // got1_q marks the cycle the FIFO presents data, so the read word lands in rgb on the next edge.
  always_comb begin
    if (got1_q)      rgb_d = vid.pix_data;
    else if (act1_q) rgb_d = UNDERFLOW_RGB;
    else             rgb_d = '0;
  end

  assign underflow_d = (act0 && vid.pix_empty) || (underflow_q && !clr_underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      act1_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      got1_q      <= 1'b0;
      first1_q    <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      act1_q      <= act0;
      hs1_q       <= hs0;
      vs1_q       <= vs0;
      got1_q      <= rd0;
      first1_q    <= first0;
      de_q        <= act1_q;
      hsync_q     <= hs1_q ? HS_POL : ~HS_POL;
      vsync_q     <= vs1_q ? VS_POL : ~VS_POL;
      fs_q        <= act1_q && first1_q;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign vid.pix_rd      = rd0;
  assign vid.rgb_out     = rgb_q;
  assign vid.hsync_out   = hsync_q;
  assign vid.vsync_out   = vsync_q;
  assign vid.de_out      = de_q;
  assign vid.frame_start = fs_q;
  assign underflow       = underflow_q;
  assign running         = run0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster, with a second positive/negative polarity instance.
// Latency: model pushes each cycle's expected outputs; monitor pops them two cycles later.
// Backpressure: bench FIFO returns data the cycle after pix_rd; empties are forced by scenario.
module tb_video_timing_gen;
  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        de;
    logic        hs;   // raw sync: 1 = in sync window
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t BLANK = '0;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic uf1, run1, uf2, run2;

  video_timing_gen_if vif();
  video_timing_gen_if vif2();

  assign vif2.pix_data  = vif.pix_data;
  assign vif2.pix_empty = vif.pix_empty;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr_underflow(clr),
    .underflow(uf1), .running(run1), .vid(vif)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut_neg (
    .clk(clk), .rst(rst), .en(en), .clr_underflow(clr),
    .underflow(uf2), .running(run2), .vid(vif2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in frame is a single index t; h = t % HT, v = t / HT.
  exp_t exp_q[$];
  bit   m_run = 1'b0;
  int   m_t = 0;
  int   m_rdcnt = 0;
  bit   m_uf = 1'b0;

  initial forever begin : model
    int   h, v;
    bit   act;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_rdcnt = 0; m_uf = 1'b0;
      exp_q.delete();
      exp_q.push_back(BLANK);
      exp_q.push_back(BLANK);
    end else begin
      h   = m_t % HT;
      v   = m_t / HT;
      act = m_run && (h < HA) && (v < VA);
      e     = BLANK;
      e.de  = act;
      e.hs  = m_run && (h >= HA + HFP) && (h < HA + HFP + HSW);
      e.vs  = m_run && (v >= VA + VFP) && (v < VA + VFP + VSW);
      e.fs  = act && (m_t == 0);
      if (act && !vif.pix_empty) begin
        e.rgb = 24'(m_rdcnt);
        m_rdcnt++;
      end else if (act) begin
        e.rgb = 24'hFF00FF;
      end
      exp_q.push_back(e);
      m_uf = (act && vif.pix_empty) || (m_uf && !clr);
      if (m_run) begin
        if (m_t == FT - 1) begin
          m_t = 0;
          if (!en) m_run = 1'b0;
        end else begin
          m_t++;
        end
      end else if (en) begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin : monitor
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("stream", {4'b0, vif.de_out, vif.hsync_out, vif.vsync_out, vif.frame_start, vif.rgb_out},
                    {4'b0, e.de, e.hs, e.vs, e.fs, e.rgb});
      chk("neg_pol_sync", {30'b0, vif2.hsync_out, vif2.vsync_out}, {30'b0, ~e.hs, ~e.vs});
      chk("status", {30'b0, run1, uf1}, {30'b0, m_run, m_uf});
    end
  end

  // ---------------- stimulus ----------------
  bit rd_pending = 1'b0;
  int fifo_val = 0;
  int ncyc = 0;
  int rd_count = 0;
  int de_rise = -1, hs_rise = -1, fs_last = -1, fs_prev = -1, fs_cnt = 0;
  bit de_prev = 1'b0, hs_prev = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (rd_pending) begin
      vif.pix_data = 24'(fifo_val);
      fifo_val++;
    end
  endtask

  task automatic drive(input bit e, input bit emp, input bit c);
    en = e;
    vif.pix_empty = emp;
    clr = c;
    #1;
    rd_pending = vif.pix_rd;
    ncyc++;
    if (vif.pix_rd) rd_count++;
    if (vif.de_out && !de_prev && de_rise < 0) de_rise = ncyc;
    if (vif.hsync_out && !hs_prev && hs_rise < 0) hs_rise = ncyc;
    if (vif.frame_start) begin
      fs_prev = fs_last;
      fs_last = ncyc;
      fs_cnt++;
    end
    de_prev = vif.de_out;
    hs_prev = vif.hsync_out;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"},   {8'b0, vif.rgb_out}, 32'd0);
    chk({tag, "_de_rd_fs"}, {29'b0, vif.de_out, vif.pix_rd, vif.frame_start}, 32'd0);
    chk({tag, "_uf_run"}, {30'b0, uf1, run1}, 32'd0);
    chk({tag, "_sync_pos"}, {30'b0, vif.hsync_out, vif.vsync_out}, 32'd0);
    chk({tag, "_sync_neg"}, {30'b0, vif2.hsync_out, vif2.vsync_out}, 32'd3);
  endtask

  int n0;
  bit done;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    vif.pix_empty = 1'b1;
    vif.pix_data  = '0;
    #1;
    check_reset_vals("por");
    repeat (2) tick();
    rst = 1'b0;
    drive(0, 0, 0);
    repeat (3) begin tick(); drive(0, 0, 0); end

    // Normal frames, FIFO never empty.
    de_rise = -1; hs_rise = -1; fs_cnt = 0;
    tick(); drive(1, 0, 0);
    n0 = ncyc;
    rd_count = 0;
    for (int i = 0; i < 2 * FT + 4; i++) begin
      tick(); drive(1, 0, 0);
      if (i == FT - 3) begin
        chk("reads_per_frame", 32'(rd_count), 32'd32);
      end
    end
    chk("en_to_de_latency", 32'(de_rise - n0), 32'd3);
    chk("hs_after_de", 32'(hs_rise - de_rise), 32'd10);
    chk("frame_period", 32'(fs_last - fs_prev), 32'(FT));

    // Randomised empties and clears.
    for (int i = 0; i < 3 * FT; i++) begin
      tick(); drive(1, $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
    end

    // Underflow on pixels 3-4 of line 0.
    done = 1'b0;
    for (int k = 0; k < 2 * FT && !done; k++) begin
      tick(); drive(1, 0, 1);
      done = m_run && (m_t == 0);
    end
    chk("wait_frame_c", 32'(done), 32'd1);
    chk("uf_cleared", {31'b0, uf1}, 32'd0);
    for (int k = 0; k < HT + 4; k++) begin
      tick();
      if (m_t == 3 || m_t == 4) begin
        drive(1, 1, 0);
        chk("no_rd_on_empty", {31'b0, vif.pix_rd}, 32'd0);
      end else if (m_t == HT) begin
        drive(1, 1, 1);             // set and clear together
      end else begin
        drive(1, 0, 0);
      end
      if (m_t == 8) chk("uf_sticky", {31'b0, uf1}, 32'd1);
    end
    chk("uf_set_wins", {31'b0, uf1}, 32'd1);
    tick(); drive(1, 0, 1);
    tick(); drive(1, 0, 0);
    chk("uf_clear", {31'b0, uf1}, 32'd0);

    // en dropped mid-frame at pixel 5 of line 2.
    done = 1'b0;
    for (int k = 0; k < 2 * FT && !done; k++) begin
      tick(); drive(1, 0, 0);
      done = m_run && (m_t == FT - 1);
    end
    chk("wait_frame_d", 32'(done), 32'd1);
    rd_count = 0;
    done = 1'b0;
    for (int k = 0; k < 3 * FT && !done; k++) begin
      tick();
      drive(!(m_t >= 2 * HT + 5) && !(rd_count > 0 && m_t == 0), 0, 0);
      done = !run1;
    end
    chk("stopped", 32'(done), 32'd1);
    chk("reads_before_stop", 32'(rd_count), 32'd32);
    for (int k = 0; k < 20; k++) begin tick(); drive(0, 0, 0); end
    chk("idle_blank", {29'b0, vif.de_out, vif.hsync_out, vif.vsync_out}, 32'd0);
    fs_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      tick(); drive(1, 0, 0);
      done = (fs_cnt > 0);
    end
    chk("restart_frame_start", 32'(done), 32'd1);

    // Reset mid-line.
    done = 1'b0;
    for (int k = 0; k < 2 * FT && !done; k++) begin
      tick(); drive(1, 0, 0);
      done = m_run && (m_t == HT + 5);
    end
    chk("wait_line_e", 32'(done), 32'd1);
    #3;
    rst = 1'b1;
    rd_pending = 1'b0;
    fifo_val = 0;
    #1;
    check_reset_vals("async");
    tick(); tick();
    rst = 1'b0;
    de_rise = -1; fs_cnt = 0; fs_last = -1;
    drive(1, 0, 0);
    n0 = ncyc;
    for (int k = 0; k < 8; k++) begin tick(); drive(1, 0, 0); end
    chk("rst_de_latency", 32'(de_rise - n0), 32'd3);
    chk("rst_fs_latency", 32'(fs_last - n0), 32'd3);
    for (int k = 0; k < FT; k++) begin tick(); drive(1, 0, 0); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
